// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and redirects on taken branches.
// Optional build macro REL_BRANCH_EN selects PC-relative branch targets instead of the target LUT.
module fetch_unit #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter int                 LUT_IDX_W  = 5,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_addr,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [INSTR_W-1:0]   instr,
  output logic [PC_W-1:0]      instr_pc,
  output logic                 instr_valid,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_wr_idx,
  input  logic [PC_W-1:0]      lut_wr_data,
  output logic                 done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;

  assign imem_addr = pc;

`ifdef REL_BRANCH_EN
  // Offset is relative to the branch instruction itself, not to the next fetch address.
  assign target = instr_pc + {{(PC_W-LUT_IDX_W){branch_idx[LUT_IDX_W-1]}}, branch_idx};

  logic unused_lut_ports;
  assign unused_lut_ports = ^{lut_we, lut_wr_idx, lut_wr_data};
`else
  logic [PC_W-1:0] lut [0:(1<<LUT_IDX_W)-1];

  // Not reset, and a same-cycle write is only seen by the following read.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut[lut_wr_idx] <= lut_wr_data;
    end
  end

  assign target = lut[branch_idx];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          instr_valid <= 1'b0;
          if (start) begin
            pc    <= start_addr;
            state <= RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            if (instr_valid && instr == HALT_INSTR) begin
              done        <= 1'b1;
              instr_valid <= 1'b0;
              state       <= HALT;
            end else if (instr_valid && branch_en) begin
              // The word fetched this cycle is squashed, giving one bubble.
              pc          <= target;
              instr_valid <= 1'b0;
            end else begin
              instr       <= imem_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + PC_W'(1);
            end
          end
        end
        HALT: begin
          if (start) begin
            done        <= 1'b0;
            pc          <= start_addr;
            instr_valid <= 1'b0;
            state       <= RUN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
